uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 43 ++++
 rtl/rx_bitclk.sv | 42 ++++
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_pkg                                                                |
// | Baud divisor constants shared with the transmitter, receiver state         |
// | encoding and the bit-timer terminal-count helper.                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

// Clocks per bit at a 50 MHz system clock; identical to the transmit side.
`ifndef B115200
`define B9600   5208
`define B19200  2604
`define B38400  1302
`define B57600  868
`define B115200 434
`endif

package uart_rx_pkg;

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
    localparam logic [2:0] c_parity = 3'd3;
    localparam logic [2:0] c_stop   = 3'd4;
    localparam logic [2:0] c_break  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = c_idle,
        ST_START  = c_start,
        ST_DATA   = c_data,
        ST_PARITY = c_parity,
        ST_STOP   = c_stop,
        ST_BREAK  = c_break
    } state_t;

    // START waits half a bit to land on mid-bit; every later state waits a full bit.
    function automatic int term_count(input int baud, input logic half);
        return half ? (baud / 2 - 1) : (baud - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_bitclk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_bitclk                                                                  |
// | Bit-period divisor for the UART receiver: ticks at half or full bit time.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rx_bitclk
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(BAUDRATE);
    localparam logic [CW-1:0] c_term_full = CW'(term_count(BAUDRATE, 1'b0));
    localparam logic [CW-1:0] c_term_half = CW'(term_count(BAUDRATE, 1'b1));

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_term;

    assign w_term = half ? c_term_half : c_term_full;
    assign tick   = (r_cnt == w_term);

    // Wrapping on terminal count keeps consecutive data bits exactly one period apart.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx                                                                    |
// | 8N1 serial receiver with mid-bit sampling, byte strobe and frame errors.   |
// | Optional even-parity check when UART_RX_PARITY_EN is defined.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE = `B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       perr,
    output logic       busy
);

`ifdef UART_RX_PARITY_EN
    localparam state_t c_after_data = ST_PARITY;
`else
    localparam state_t c_after_data = ST_STOP;
`endif

    logic       r_rx_meta;
    logic       r_rxs;
    logic       r_rxs_d;
    state_t     r_state;
    state_t     w_state_next;
    logic       w_tick;
    logic       w_clr;
    logic       w_half;
    logic       w_start_ok;
    logic       w_shift;
    logic       w_done;
    logic       w_ferr;
    logic [7:0] r_shift;
    logic [2:0] r_idx;
    logic [7:0] r_data;
    logic       r_rcv;
    logic       r_ferr;
`ifdef UART_RX_PARITY_EN
    logic       w_par_cap;
    logic       r_par;
    logic       r_perr;
`endif

    // Start detection looks at rxs one cycle later so START is entered three
    // edges after the line is first seen low, centring all later samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    rx_bitclk #(
        .BAUDRATE (BAUDRATE)
    ) u_bitclk (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_clr),
        .half (w_half),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_cap    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_rxs_d) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    if (!r_rxs) begin
                        w_start_ok   = 1'b1;
                        w_state_next = ST_DATA;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_idx == 3'd7) w_state_next = c_after_data;
                end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_tick) begin
                    w_par_cap    = 1'b1;
                    w_state_next = ST_STOP;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_rxs) begin
                        w_done       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must not be parsed as a run of 0x00 frames.
                if (r_rxs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        w_half = (r_state == ST_START);
        w_clr  = (r_state == ST_IDLE) || (w_state_next != r_state);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= 8'h00;
            r_idx   <= 3'd0;
            r_data  <= 8'h00;
            r_rcv   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_rcv  <= w_done;
            r_ferr <= w_ferr;
            if (w_start_ok) begin
                r_shift <= 8'h00;
                r_idx   <= 3'd0;
            end else if (w_shift) begin
                r_shift <= {r_rxs, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
            end
            if (w_done) r_data <= r_shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (w_par_cap) r_par <= r_rxs;
            r_perr <= w_done & ((^r_shift) ^ r_par);
        end
    end

    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    assign data = r_data;
    assign rcv  = r_rcv;
    assign ferr = r_ferr;
    assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx                                                                 |
// | Self-checking bench for uart_rx: directed and random frames vs. a          |
// | frame-level timing model. Honours UART_RX_PARITY_EN.                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_rx;

    localparam int BR = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    typedef struct {
        int cyc;
        int d;
        int r;
        int f;
        int p;
    } ev_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       perr;
    logic       busy;

    int         cyc       = 0;
    int         n_cmp     = 0;
    int         n_err     = 0;
    logic [7:0] last_good = 8'h00;
    logic       busy_prev = 1'b0;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  obs_rise[$];
    int  exp_rise[$];
    int  obs_fall[$];
    int  exp_fall[$];

    uart_rx #(
        .BAUDRATE (BR)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr),
        .perr (perr),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe cycle and busy edge, stamped with the last rising-edge index.
    always @(negedge clk) begin
        if (rstn) begin
            if (rcv || ferr || perr)
                obs_q.push_back('{cyc, int'(data), int'(rcv), int'(ferr), int'(perr)});
            if (busy && !busy_prev) obs_rise.push_back(cyc);
            if (!busy && busy_prev) obs_fall.push_back(cyc);
        end
        busy_prev <= busy;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick_n(BR);
    endtask

    // Model: E is the edge that first samples the start bit; stop sampled at
    // E+3+BR/2+(9+NPAR)*BR, strobes visible in the following cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic pbit,
                              input int hold_low, input int gap);
        int e;
        int s;
        e = cyc + 1;
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(b[k]);
        if (NPAR == 1) drive_bit(pbit);
        drive_bit(stop_ok);
        s = e + 3 + BR / 2 + (9 + NPAR) * BR;
        exp_rise.push_back(e + 3);
        if (stop_ok) begin
            exp_q.push_back('{s, int'(b), 1, 0, (NPAR == 1) ? int'((^b) ^ pbit) : 0});
            exp_fall.push_back(s);
            last_good = b;
        end else begin
            exp_q.push_back('{s, int'(last_good), 0, 1, 0});
            tick_n(hold_low);
            // line seen high at cyc+1, through two sync flops, then BREAK exits
            exp_fall.push_back(cyc + 3);
        end
        rx = 1'b1;
        tick_n(gap);
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s n_events", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s ev%0d cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s ev%0d data", tag, i), obs_q[i].d, exp_q[i].d);
            check($sformatf("%s ev%0d rcv", tag, i), obs_q[i].r, exp_q[i].r);
            check($sformatf("%s ev%0d ferr", tag, i), obs_q[i].f, exp_q[i].f);
            check($sformatf("%s ev%0d perr", tag, i), obs_q[i].p, exp_q[i].p);
        end
        check($sformatf("%s n_busy_rise", tag), obs_rise.size(), exp_rise.size());
        for (int i = 0; i < obs_rise.size() && i < exp_rise.size(); i++)
            check($sformatf("%s busy_rise%0d", tag, i), obs_rise[i], exp_rise[i]);
        check($sformatf("%s n_busy_fall", tag), obs_fall.size(), exp_fall.size());
        for (int i = 0; i < obs_fall.size() && i < exp_fall.size(); i++)
            check($sformatf("%s busy_fall%0d", tag, i), obs_fall[i], exp_fall[i]);
        obs_q.delete();
        exp_q.delete();
        obs_rise.delete();
        exp_rise.delete();
        obs_fall.delete();
        exp_fall.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data"}, int'(data), 0);
        check({tag, " rcv"}, int'(rcv), 0);
        check({tag, " ferr"}, int'(ferr), 0);
        check({tag, " perr"}, int'(perr), 0);
        check({tag, " busy"}, int'(busy), 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        logic       pb;
        int         gap;
        int         hold;
        int         e;

        tick_n(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick_n(5);

        send_frame(8'h55, 1'b1, ^8'h55, 0, 20);
        compare_all("x55");

        send_frame(8'hA3, 1'b1, ^8'hA3, 0, 0);
        send_frame(8'h0F, 1'b1, ^8'h0F, 0, 20);
        compare_all("b2b");

        // start bit shorter than half a bit: sampled high at mid-start, back to idle
        e = cyc + 1;
        rx = 1'b0;
        tick_n(4);
        rx = 1'b1;
        exp_rise.push_back(e + 3);
        exp_fall.push_back(e + 3 + BR / 2);
        tick_n(30);
        compare_all("glitch");
        check("glitch data", int'(data), int'(last_good));

        send_frame(8'h3C, 1'b0, 1'b0, 40, 20);
        compare_all("break");
        check("break data", int'(data), int'(last_good));

        // reset after four data bits of a frame
        rx = 1'b0;
        tick_n(BR);
        b = 8'hC6;
        for (int k = 0; k < 4; k++) drive_bit(b[k]);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        rx = 1'b1;
        tick_n(4);
        obs_q.delete();
        obs_rise.delete();
        obs_fall.delete();
        exp_q.delete();
        exp_rise.delete();
        exp_fall.delete();
        last_good = 8'h00;
        rstn = 1'b1;
        tick_n(5);
        send_frame(8'h81, 1'b1, ^8'h81, 0, 20);
        compare_all("after_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0, 20);
        compare_all("par_bad");
        send_frame(8'h07, 1'b1, 1'b1, 0, 20);
        compare_all("par_good");
`endif

        for (int n = 0; n < 14; n++) begin
            b    = 8'($urandom);
            ok   = ($urandom_range(0, 3) != 0);
            pb   = 1'($urandom_range(0, 1));
            gap  = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
            hold = ok ? 0 : int'($urandom_range(0, 20));
            send_frame(b, ok, pb, hold, gap);
        end
        tick_n(30);
        compare_all("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
